keypad_scanner: RTL and testbench

- Parametrised matrix-keypad scanner; next generation of the 4x4 keypad controller.
- Drives columns one at a time and samples rows through a synchroniser.
- Debounces whole-matrix snapshots and queues key codes in a small FIFO.
- Raises an interrupt to the host bus logic while codes are pending.

---
 rtl/keypad_pkg.sv | 30 +++
 rtl/keypad_code_fifo.sv | 58 +++++
 rtl/keypad_scanner.sv | 158 +++++++++++++++
 tb/tb_keypad_scanner.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared constants and helpers for the matrix keypad scanner: scan FSM
// state encoding, width derivation and key-code arithmetic.
package keypad_pkg;

  typedef logic [0:0] scan_state_t;
  localparam scan_state_t ST_SCAN = 1'b0;
  localparam scan_state_t ST_EVAL = 1'b1;

  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v = value - 1;
    while (v > 0) begin
      result = result + 1;
      v = v >> 1;
    end
    return result;
  endfunction

  // Width of a key code able to name every key of a rows x cols matrix.
  function automatic int key_width(input int rows, input int cols);
    return clog2(rows * cols);
  endfunction

  function automatic int code_of(input int r, input int c, input int cols);
    return r * cols + c;
  endfunction

endpackage

// File: rtl/keypad_code_fifo.sv
// Small key-code queue with a sticky overflow flag; the head entry is
// presented combinationally from storage.
module keypad_code_fifo
  import keypad_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop_req,
  output logic [WIDTH-1:0] head,
  output logic             valid,
  output logic             overflow
);

  localparam int AW = clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE_COUNT  = (AW+1)'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             full;
  logic             pop;
  logic             do_push;

  assign valid   = (count != '0);
  assign full    = (count == FULL_COUNT);
  assign pop     = pop_req && valid;
  // A pop frees a slot in the same cycle, so a full queue still accepts.
  assign do_push = push && (!full || pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !pop) count <= count + 1'b1;
      else if (pop && !do_push) count <= count - 1'b1;
      if (push && full && !pop) overflow <= 1'b1;
      else if (pop && !do_push && count == ONE_COUNT) overflow <= 1'b0;
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// Matrix keypad scanner: column drive, row synchroniser, whole-matrix debounce
// and key-code queue. Define KEYPAD_AUTOREPEAT_EN to enable auto-repeat.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int ROWS          = 4,
  parameter int COLS          = 4,
  parameter int SCAN_DIV      = 1000,
  parameter int DEBOUNCE      = 4,
  parameter int FIFO_DEPTH    = 4,
  parameter int REPEAT_SWEEPS = 64
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [ROWS-1:0]                     row,
  output logic [COLS-1:0]                     column,
  output logic [key_width(ROWS, COLS)-1:0]    key_data,
  output logic                                key_valid,
  input  logic                                key_ack,
  output logic                                interrupt,
  output logic                                overflow
);

  localparam int KW = key_width(ROWS, COLS);
  localparam int N  = ROWS * COLS;
  localparam int IW = clog2(COLS);
  localparam int DW = clog2(SCAN_DIV);
  localparam int CW = clog2(DEBOUNCE + 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(COLS - 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] DEB_MAX  = CW'(DEBOUNCE);

  logic [ROWS-1:0] row_meta;
  logic [ROWS-1:0] row_sync;
  scan_state_t     state;
  logic [IW-1:0]   idx;
  logic [DW-1:0]   div;
  logic [N-1:0]    snapshot;
  logic [N-1:0]    prev_snapshot;
  logic [N-1:0]    stable;
  logic [CW-1:0]   dcnt;

  logic [CW-1:0]   dcnt_next;
  logic            accept;
  logic [N-1:0]    new_press;
  logic [KW-1:0]   press_code;
  logic            rep_push;
  logic [KW-1:0]   held_code;
  logic            push;
  logic [KW-1:0]   push_code;

  // Snapshot bit c*ROWS+r is key (r,c); lowest bit index wins.
  always_comb begin
    if (snapshot == prev_snapshot) dcnt_next = (dcnt == DEB_MAX) ? dcnt : dcnt + 1'b1;
    else dcnt_next = CW'(1);
    accept    = (dcnt_next == DEB_MAX);
    new_press = snapshot & ~stable;
    press_code = '0;
    for (int c = COLS - 1; c >= 0; c--)
      for (int r = ROWS - 1; r >= 0; r--)
        if (new_press[c*ROWS+r]) press_code = KW'(code_of(r, c, COLS));
  end

`ifdef KEYPAD_AUTOREPEAT_EN
  localparam int RW = clog2(REPEAT_SWEEPS + 1);
  localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_SWEEPS);

  logic [RW-1:0] rep_cnt;
  logic [RW-1:0] rep_next;
  logic [RW-1:0] rep_inc;
  logic [N-1:0]  stable_next;

  always_comb begin
    stable_next = accept ? snapshot : stable;
    rep_inc     = rep_cnt + 1'b1;
    rep_next    = '0;
    rep_push    = 1'b0;
    held_code   = '0;
    for (int c = COLS - 1; c >= 0; c--)
      for (int r = ROWS - 1; r >= 0; r--)
        if (stable[c*ROWS+r]) held_code = KW'(code_of(r, c, COLS));
    if (stable_next == stable && $onehot(stable)) begin
      if (rep_inc == REP_LAST) rep_push = 1'b1;
      else rep_next = rep_inc;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) rep_cnt <= '0;
    else if (state == ST_EVAL) rep_cnt <= rep_next;
  end
`else
  assign rep_push  = 1'b0;
  assign held_code = '0;
`endif

  assign push      = (state == ST_EVAL) && ((accept && (|new_press)) || rep_push);
  assign push_code = (accept && (|new_press)) ? press_code : held_code;

  always_ff @(posedge clk) begin
    if (reset) begin
      row_meta      <= '1;
      row_sync      <= '1;
      column        <= '1;
      state         <= ST_SCAN;
      idx           <= '0;
      div           <= '0;
      snapshot      <= '0;
      prev_snapshot <= '0;
      stable        <= '0;
      dcnt          <= '0;
    end else begin
      row_meta <= row;
      row_sync <= row_meta;
      column   <= (state == ST_SCAN) ? ~(COLS'(1) << idx) : '1;
      case (state)
        ST_SCAN: begin
          if (div == DIV_LAST) begin
            snapshot[idx*ROWS +: ROWS] <= ~row_sync;
            div <= '0;
            if (idx == IDX_LAST) begin
              idx   <= '0;
              state <= ST_EVAL;
            end else begin
              idx <= idx + 1'b1;
            end
          end else begin
            div <= div + 1'b1;
          end
        end
        ST_EVAL: begin
          dcnt          <= dcnt_next;
          prev_snapshot <= snapshot;
          if (accept) stable <= snapshot;
          state <= ST_SCAN;
        end
        default: state <= ST_SCAN;
      endcase
    end
  end

  keypad_code_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (KW)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (push_code),
    .pop_req   (key_ack),
    .head      (key_data),
    .valid     (key_valid),
    .overflow  (overflow)
  );

  assign interrupt = key_valid;

endmodule

// File: tb/tb_keypad_scanner.sv
// Scoreboard bench for keypad_scanner: a keypad matrix model drives the rows,
// expected codes are queued on key presses and checked as the host acks them.
module tb_keypad_scanner;

  logic        clk;
  logic        reset;
  logic [3:0]  row;
  logic [3:0]  column;
  logic [3:0]  key_data;
  logic        key_valid;
  logic        key_ack;
  logic        interrupt;
  logic        overflow;

  logic [15:0] keys;
  logic [3:0]  exp_q[$];
  int          n_tests;
  int          n_fail;

  keypad_scanner #(
    .ROWS          (4),
    .COLS          (4),
    .SCAN_DIV      (4),
    .DEBOUNCE      (2),
    .FIFO_DEPTH    (2),
    .REPEAT_SWEEPS (3)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .row       (row),
    .column    (column),
    .key_data  (key_data),
    .key_valid (key_valid),
    .key_ack   (key_ack),
    .interrupt (interrupt),
    .overflow  (overflow)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // keypad matrix: key code r*4+c pulls row r low while column c is driven low
  always_comb begin
    row = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && column[c] == 1'b0) row[r] = 1'b0;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic wait_sweeps(input int n);
    int seen;
    int t;
    seen = 0;
    t = 0;
    while (seen < n && t < n * 40) begin
      @(negedge clk);
      t++;
      if (column == 4'hF) seen++;
    end
    if (seen < n) check("sweep_timeout", seen, n);
  endtask

  task automatic press(input int code);
    keys[code] = 1'b1;
  endtask

  task automatic release_all();
    keys = '0;
  endtask

  task automatic drain_one();
    int t;
    logic [3:0] e;
    t = 0;
    while (key_valid !== 1'b1 && t < 400) begin
      @(negedge clk);
      t++;
    end
    e = exp_q.pop_front();
    check("valid_wait", key_valid, 1'b1);
    if (key_valid === 1'b1) begin
      check("key_data", key_data, e);
      check("interrupt_hi", interrupt, 1'b1);
      key_ack = 1'b1;
      @(negedge clk);
      key_ack = 1'b0;
    end
  endtask

  task automatic drain();
    while (exp_q.size() > 0) drain_one();
  endtask

  initial begin
    logic [3:0] exp_col;
    int t;
    n_tests = 0;
    n_fail  = 0;
    keys    = '0;
    key_ack = 1'b0;
    reset   = 1'b1;

    // reset held 3 cycles, then the column walk
    repeat (3) @(negedge clk);
    check("rst_column", column, 4'hF);
    check("rst_valid", key_valid, 1'b0);
    check("rst_irq", interrupt, 1'b0);
    check("rst_ovf", overflow, 1'b0);
    check("rst_data", key_data, 4'h0);
    reset = 1'b0;
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      exp_col = (i < 16) ? ~(4'b0001 << (i / 4)) : 4'b1111;
      check("walk_column", column, exp_col);
    end
    check("walk_valid", key_valid, 1'b0);

    // single key 9, with latency: valid rises together with the post-EVAL column
    press(9);
    exp_q.push_back(4'd9);
    t = 0;
    while (key_valid !== 1'b1 && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("latency_column", column, 4'hF);
    drain();
    check("ack_valid", key_valid, 1'b0);
    check("ack_irq", interrupt, 1'b0);
    release_all();
    wait_sweeps(3);

    // one-sweep glitch on row 0 must not produce a code
    press(0);
    repeat (10) @(negedge clk);
    release_all();
    wait_sweeps(4);
    check("glitch_valid", key_valid, 1'b0);

    // simultaneous 5 and 10: only 5; then 10 alone
    press(5);
    press(10);
    exp_q.push_back(4'd5);
    wait_sweeps(3);
    drain();
    wait_sweeps(1);
    check("simul_extra", key_valid, 1'b0);
    release_all();
    wait_sweeps(3);
    press(10);
    exp_q.push_back(4'd10);
    wait_sweeps(3);
    release_all();
    drain();
    wait_sweeps(3);

    // three presses without ack: third dropped, overflow sticky
    press(1);
    exp_q.push_back(4'd1);
    wait_sweeps(3);
    release_all();
    wait_sweeps(3);
    press(6);
    exp_q.push_back(4'd6);
    wait_sweeps(3);
    release_all();
    wait_sweeps(3);
    press(11);
    wait_sweeps(3);
    release_all();
    wait_sweeps(3);
    check("ovf_set", overflow, 1'b1);
    drain_one();
    check("ovf_after_one", overflow, 1'b1);
    drain_one();
    check("ovf_clear", overflow, 1'b0);
    check("ovf_empty", key_valid, 1'b0);

    // held key 7
`ifdef KEYPAD_AUTOREPEAT_EN
    press(7);
    for (int i = 0; i < 3; i++) exp_q.push_back(4'd7);
    drain();
    release_all();
    wait_sweeps(4);
    check("repeat_stop", key_valid, 1'b0);
`else
    press(7);
    exp_q.push_back(4'd7);
    wait_sweeps(10);
    drain();
    wait_sweeps(4);
    check("no_repeat", key_valid, 1'b0);
    release_all();
    wait_sweeps(3);
`endif

    // reset mid-scan flushes the queue and restarts at column 0
    press(9);
    wait_sweeps(3);
    release_all();
    check("pre_rst_valid", key_valid, 1'b1);
    repeat (6) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("mid_rst_column", column, 4'hF);
    check("mid_rst_valid", key_valid, 1'b0);
    check("mid_rst_ovf", overflow, 1'b0);
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_col0", column, 4'hE);
    repeat (3) @(negedge clk);
    check("post_rst_col0_end", column, 4'hE);
    @(negedge clk);
    check("post_rst_col1", column, 4'hD);
    wait_sweeps(3);
    check("post_rst_valid", key_valid, 1'b0);

    check("scoreboard_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
